// File: rtl/logic_box_cfg_loader.sv
// logic_box_cfg_loader
//   Serial configuration loader for NUM_TILES Logic_box tiles. A bit-serial stream arrives over a
//   valid/ready handshake. The loader hunts for SYNC_WORD, then shifts one FRAME_W-bit frame per
//   tile (tile 0 first, MSB first) into shadow registers. After the last frame it commits every
//   shadow slot to the active outputs in a single cycle, so tiles only ever see a complete
//   configuration.
//
//   Frame layout, MSB to LSB: sel_direction_BLEout[3:0], sel_direction[1:0], sel, lut[15:0].
//
//   Optional feature (macro LOGIC_BOX_CFG_PARITY_EN): each frame is followed by one parity bit,
//   which gives even parity over the frame plus the parity bit. A bad parity bit discards the
//   shadow contents and parks the loader in ERROR until the next start.
//
// Ports
//   clk                  : system clock, rising edge
//   reset                : synchronous, active-high reset
//   start                : one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   bit_in, bit_valid    : serial data and its valid strobe
//   bit_ready            : loader accepts a bit this cycle (SYNC and LOAD)
//   lut                  : active LUT contents, tile k at [16k+15:16k]
//   sel                  : active sel, one bit per tile
//   sel_direction        : active sel_direction, 2 bits per tile
//   sel_direction_BLEout : active BLE output direction, 4 bits per tile
//   cfg_busy             : high in SYNC, LOAD and COMMIT
//   cfg_done             : high in DONE
//   cfg_error            : high in ERROR (always 0 without the parity option)
module logic_box_cfg_loader #(
  parameter int unsigned NUM_TILES = 2,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic [16*NUM_TILES-1:0]  lut,
  output logic [NUM_TILES-1:0]     sel,
  output logic [2*NUM_TILES-1:0]   sel_direction,
  output logic [4*NUM_TILES-1:0]   sel_direction_BLEout,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_error
);

  // Tied to the Logic_box port widths: 16 lut + 1 sel + 2 sel_direction + 4 BLEout.
  localparam int unsigned FRAME_W  = 23;
  localparam int unsigned TileCntW = $clog2(NUM_TILES + 1);

`ifdef LOGIC_BOX_CFG_PARITY_EN
  // The full frame must be held while the trailing parity bit is checked.
  localparam int unsigned FrameRegW = FRAME_W;
  localparam logic [4:0]  LastBit   = 5'(FRAME_W);
`else
  // The final frame bit goes straight from bit_in into the shadow slot.
  localparam int unsigned FrameRegW = FRAME_W - 1;
  localparam logic [4:0]  LastBit   = 5'(FRAME_W - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StLoad,
    StCommit,
    StDone,
    StError
  } state_e;

  state_e                 state_q, state_d;
  // Only 7 bits are stored; the 8th bit of the sync window is the incoming bit_in.
  logic [6:0]             window_q, window_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [TileCntW-1:0]    tile_cnt_q, tile_cnt_d;
  logic [FrameRegW-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]     shadow_q [NUM_TILES];
  logic [FRAME_W-1:0]     shadow_d [NUM_TILES];
  logic [16*NUM_TILES-1:0] lut_q, lut_d;
  logic [NUM_TILES-1:0]    sel_q, sel_d;
  logic [2*NUM_TILES-1:0]  dir_q, dir_d;
  logic [4*NUM_TILES-1:0]  ble_q, ble_d;

  logic                   xfer;
  logic [FRAME_W-1:0]     shifted;
  logic [FRAME_W-1:0]     frame_word;
  logic                   frame_good;

  assign bit_ready = (state_q == StSync) || (state_q == StLoad);
  assign cfg_busy  = (state_q == StSync) || (state_q == StLoad) || (state_q == StCommit);
  assign cfg_done  = (state_q == StDone);
`ifdef LOGIC_BOX_CFG_PARITY_EN
  assign cfg_error = (state_q == StError);
`else
  assign cfg_error = 1'b0;
`endif

  assign lut                  = lut_q;
  assign sel                  = sel_q;
  assign sel_direction        = dir_q;
  assign sel_direction_BLEout = ble_q;

  assign xfer    = bit_valid & bit_ready;
  assign shifted = {frame_q[FRAME_W-2:0], bit_in};

`ifdef LOGIC_BOX_CFG_PARITY_EN
  assign frame_word = frame_q;
  assign frame_good = (bit_in == ^frame_q);
`else
  assign frame_word = shifted;
  assign frame_good = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    bit_cnt_d  = bit_cnt_q;
    tile_cnt_d = tile_cnt_q;
    frame_d    = frame_q;
    shadow_d   = shadow_q;
    lut_d      = lut_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    ble_d      = ble_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d  = StSync;
          window_d = '0;
        end
      end

      StSync: begin
        if (xfer) begin
          if ({window_q, bit_in} == SYNC_WORD) begin
            state_d    = StLoad;
            window_d   = '0;
            bit_cnt_d  = '0;
            tile_cnt_d = '0;
          end else begin
            window_d = {window_q[5:0], bit_in};
          end
        end
      end

      StLoad: begin
        if (xfer) begin
          if (bit_cnt_q != LastBit) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            frame_d   = shifted[FrameRegW-1:0];
          end else if (!frame_good) begin
            state_d = StError;
            for (int k = 0; k < NUM_TILES; k++) begin
              shadow_d[k] = '0;
            end
          end else begin
            for (int k = 0; k < NUM_TILES; k++) begin
              if (tile_cnt_q == TileCntW'(k)) begin
                shadow_d[k] = frame_word;
              end
            end
            bit_cnt_d  = '0;
            tile_cnt_d = tile_cnt_q + TileCntW'(1);
            if (tile_cnt_q == TileCntW'(NUM_TILES - 1)) begin
              state_d = StCommit;
            end
          end
        end
      end

      StCommit: begin
        for (int k = 0; k < NUM_TILES; k++) begin
          lut_d[16*k +: 16] = shadow_q[k][15:0];
          sel_d[k]          = shadow_q[k][16];
          dir_d[2*k +: 2]   = shadow_q[k][18:17];
          ble_d[4*k +: 4]   = shadow_q[k][22:19];
        end
        state_d = StDone;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      window_q   <= '0;
      bit_cnt_q  <= '0;
      tile_cnt_q <= '0;
      frame_q    <= '0;
      for (int k = 0; k < NUM_TILES; k++) begin
        shadow_q[k] <= '0;
      end
      lut_q <= '0;
      sel_q <= '0;
      dir_q <= '0;
      ble_q <= '0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      bit_cnt_q  <= bit_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      frame_q    <= frame_d;
      shadow_q   <= shadow_d;
      lut_q      <= lut_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      ble_q      <= ble_d;
    end
  end

endmodule

// File: tb/tb_logic_box_cfg_loader.sv
// Testbench for logic_box_cfg_loader: table-driven loads, randomized loads checked against a
// bit-stream reference model, and hand-written sequences for reset, ignored inputs, sync hunting
// and (with LOGIC_BOX_CFG_PARITY_EN) parity errors.
module tb_logic_box_cfg_loader;

  localparam int NT = 2;
  localparam int FW = 23;
`ifdef LOGIC_BOX_CFG_PARITY_EN
  localparam int FL = FW + 1;
`else
  localparam int FL = FW;
`endif
  localparam logic [7:0] SYNC = 8'hA5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              bit_ready;
  logic [16*NT-1:0]  lut;
  logic [NT-1:0]     sel;
  logic [2*NT-1:0]   sel_direction;
  logic [4*NT-1:0]   sel_direction_BLEout;
  logic              cfg_busy, cfg_done, cfg_error;

  logic_box_cfg_loader #(
    .NUM_TILES (NT),
    .SYNC_WORD (SYNC)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .bit_in               (bit_in),
    .bit_valid            (bit_valid),
    .bit_ready            (bit_ready),
    .lut                  (lut),
    .sel                  (sel),
    .sel_direction        (sel_direction),
    .sel_direction_BLEout (sel_direction_BLEout),
    .cfg_busy             (cfg_busy),
    .cfg_done             (cfg_done),
    .cfg_error            (cfg_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected active configuration, plus its value before the load in progress.
  logic [16*NT-1:0] exp_lut, old_lut;
  logic [NT-1:0]    exp_sel;
  logic [2*NT-1:0]  exp_dir;
  logic [4*NT-1:0]  exp_ble;

  bit sq[$];
  bit stall_bad;

  typedef struct {
    logic [3:0]  ble0;
    logic [1:0]  dir0;
    logic        sel0;
    logic [15:0] lut0;
    logic [3:0]  ble1;
    logic [1:0]  dir1;
    logic        sel1;
    logic [15:0] lut1;
    logic [31:0] e_lut;
    logic [1:0]  e_sel;
    logic [3:0]  e_dir;
    logic [7:0]  e_ble;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".lut"}, 64'(lut), 64'(exp_lut));
    chk({tag, ".sel"}, 64'(sel), 64'(exp_sel));
    chk({tag, ".sel_direction"}, 64'(sel_direction), 64'(exp_dir));
    chk({tag, ".sel_direction_BLEout"}, 64'(sel_direction_BLEout), 64'(exp_ble));
  endtask

  task automatic chk_flags(input string tag, input bit busy, input bit done, input bit rdy,
                           input bit err);
    chk({tag, ".cfg_busy"}, 64'(cfg_busy), 64'(busy));
    chk({tag, ".cfg_done"}, 64'(cfg_done), 64'(done));
    chk({tag, ".bit_ready"}, 64'(bit_ready), 64'(rdy));
    chk({tag, ".cfg_error"}, 64'(cfg_error), 64'(err));
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) sq.push_back(b[j]);
  endtask

  // Frame bits MSB first; with parity, an even-parity bit (optionally inverted) follows.
  task automatic push_frame(input logic [FW-1:0] f, input bit flip);
    for (int j = FW - 1; j >= 0; j--) sq.push_back(f[j]);
`ifdef LOGIC_BOX_CFG_PARITY_EN
    sq.push_back((^f) ^ flip);
`else
    if (flip) sq.push_back(1'b0);
`endif
  endtask

  // Reference model: find the first point where the last 8 bits equal SYNC, then carve the
  // following bits into per-tile frames. Returns bits consumed and whether a parity error occurs.
  function automatic void model_run(output int n_bits, output bit err);
    logic [7:0]       w;
    logic [FW-1:0]    f;
    logic [16*NT-1:0] nl;
    logic [NT-1:0]    ns;
    logic [2*NT-1:0]  nd;
    logic [4*NT-1:0]  nb;
    int               i;
    w   = 8'h00;
    i   = 0;
    err = 1'b0;
    while (i < sq.size()) begin
      w = {w[6:0], sq[i]};
      i++;
      if (w == SYNC) break;
    end
    nl = exp_lut; ns = exp_sel; nd = exp_dir; nb = exp_ble;
    for (int t = 0; t < NT && !err; t++) begin
      f = '0;
      for (int j = 0; j < FW; j++) begin
        f = {f[FW-2:0], sq[i]};
        i++;
      end
`ifdef LOGIC_BOX_CFG_PARITY_EN
      if (sq[i] != ^f) err = 1'b1;
      i++;
`endif
      if (!err) begin
        nl[16*t +: 16] = f[15:0];
        ns[t]          = f[16];
        nd[2*t +: 2]   = f[18:17];
        nb[4*t +: 4]   = f[22:19];
      end
    end
    n_bits = i;
    if (!err) begin
      exp_lut = nl; exp_sel = ns; exp_dir = nd; exp_ble = nb;
    end
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one bit after a random number of stall cycles; returns #1 after the accepting edge.
  task automatic send_bit(input bit b, input int stall_pct, input bit with_start);
    int guard;
    while (int'($urandom_range(99)) < stall_pct) begin
      bit_valid = 1'b0;
      @(negedge clk);
      if (!bit_ready || !cfg_busy) stall_bad = 1'b1;
      @(posedge clk); #1;
    end
    bit_valid = 1'b1;
    bit_in    = b;
    start     = with_start;
    guard     = 0;
    while (!bit_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) chk("bit_ready_wait", 64'(bit_ready), 64'd1);
    @(posedge clk); #1;
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  // Sends the first n_bits of sq after a start pulse and checks the commit timing.
  task automatic run_load(input int n_bits, input bit err, input int stall_pct,
                          input int start_at, input string tag);
    pulse_start();
    @(negedge clk);
    chk_flags({tag, ".start"}, 1'b1, 1'b0, 1'b1, 1'b0);
    stall_bad = 1'b0;
    for (int i = 0; i < n_bits; i++) send_bit(sq[i], stall_pct, i == start_at);
    chk({tag, ".ready_in_stall"}, 64'(stall_bad), 64'd0);
    @(negedge clk);
    if (err) begin
      chk_flags({tag, ".error"}, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_outs({tag, ".error"});
    end else begin
      chk({tag, ".precommit_lut"}, 64'(lut), 64'(old_lut));
      chk({tag, ".precommit_done"}, 64'(cfg_done), 64'd0);
      chk({tag, ".precommit_busy"}, 64'(cfg_busy), 64'd1);
      @(negedge clk);
      chk_outs({tag, ".commit"});
      chk_flags({tag, ".commit"}, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic table_load(input int v, input int stall_pct, input int start_at);
    sq.delete();
    push_byte(SYNC);
    push_frame({vecs[v].ble0, vecs[v].dir0, vecs[v].sel0, vecs[v].lut0}, 1'b0);
    push_frame({vecs[v].ble1, vecs[v].dir1, vecs[v].sel1, vecs[v].lut1}, 1'b0);
    old_lut = exp_lut;
    exp_lut = vecs[v].e_lut;
    exp_sel = vecs[v].e_sel;
    exp_dir = vecs[v].e_dir;
    exp_ble = vecs[v].e_ble;
    run_load(8 + NT * FL, 1'b0, stall_pct, start_at, $sformatf("vec%0d", v));
  endtask

  task automatic random_load(input int stall_pct, input bit mid_start);
    int glen;
    int n;
    bit e;
    sq.delete();
    glen = int'($urandom_range(12));
    repeat (glen) sq.push_back(1'($urandom_range(1)));
    push_byte(SYNC);
    for (int t = 0; t < NT; t++) push_frame(FW'($urandom), 1'b0);
    old_lut = exp_lut;
    model_run(n, e);
    run_load(n, e, stall_pct, mid_start ? glen + 12 : -1, "rand");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    bit e;
    vecs[0] = '{4'b0010, 2'b00, 1'b0, 16'h5555, 4'b0001, 2'b11, 1'b1, 16'hF00F,
                32'hF00F_5555, 2'b10, 4'b1100, 8'h12};
    vecs[1] = '{4'b1111, 2'b01, 1'b1, 16'h1234, 4'b0000, 2'b10, 1'b0, 16'hABCD,
                32'hABCD_1234, 2'b01, 4'b1001, 8'h0F};
    vecs[2] = '{4'b1010, 2'b10, 1'b1, 16'h0000, 4'b0101, 2'b01, 1'b1, 16'hFFFF,
                32'hFFFF_0000, 2'b11, 4'b0110, 8'h5A};
    exp_lut = '0; exp_sel = '0; exp_dir = '0; exp_ble = '0; old_lut = '0;

    // Reset held for two cycles.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_outs("reset");
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // bit_valid in IDLE is not consumed.
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_flags("idle_valid", 1'b0, 1'b0, 1'b0, 1'b0);
    bit_valid = 1'b0;

    for (int v = 0; v < 3; v++) table_load(v, 0, -1);

    // bit_valid in DONE is ignored and outputs hold.
    bit_valid = 1'b1; bit_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_flags("done_valid", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_outs("done_valid");
    bit_valid = 1'b0;

    // Sync hunting: 8'h52 then SYNC, followed by vec0 frames; the model locates the sync point.
    sq.delete();
    push_byte(8'h52);
    push_byte(SYNC);
    push_frame({vecs[0].ble0, vecs[0].dir0, vecs[0].sel0, vecs[0].lut0}, 1'b0);
    push_frame({vecs[0].ble1, vecs[0].dir1, vecs[0].sel1, vecs[0].lut1}, 1'b0);
    push_frame(FW'($urandom), 1'b0);
    old_lut = exp_lut;
    model_run(n, e);
    run_load(n, e, 0, -1, "hunt");

    // Stalled load and a load with start pulsed mid-LOAD.
    table_load(0, 40, -1);
    table_load(1, 0, 20);

    for (int r = 0; r < 8; r++) random_load(30, r[0]);

    // Reset after tile 0's 10th bit discards everything.
    sq.delete();
    push_byte(SYNC);
    for (int t = 0; t < NT; t++) push_frame(FW'($urandom), 1'b0);
    pulse_start();
    for (int i = 0; i < 18; i++) send_bit(sq[i], 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_lut = '0; exp_sel = '0; exp_dir = '0; exp_ble = '0;
    @(negedge clk);
    chk_outs("reset_mid");
    chk_flags("reset_mid", 1'b0, 1'b0, 1'b0, 1'b0);

    table_load(2, 20, -1);

`ifdef LOGIC_BOX_CFG_PARITY_EN
    // Good parity on tile 0, flipped parity on tile 1.
    sq.delete();
    push_byte(SYNC);
    push_frame({vecs[0].ble0, vecs[0].dir0, vecs[0].sel0, vecs[0].lut0}, 1'b0);
    push_frame({vecs[0].ble1, vecs[0].dir1, vecs[0].sel1, vecs[0].lut1}, 1'b1);
    old_lut = exp_lut;
    model_run(n, e);
    run_load(n, e, 0, -1, "parity");
    pulse_start();
    @(negedge clk);
    chk_flags("parity_restart", 1'b1, 1'b0, 1'b1, 1'b0);
    chk_outs("parity_restart");
    random_load(20, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
